// File: rtl/dram_lsu_bridge_pkg.sv
// Shared encodings for the DRAM load/store bridge: access sizes and FSM states.
package dram_lsu_bridge_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // True when the access cannot be issued: reserved size or natural-alignment violation.
    function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_RSV)
            || (size == SZ_H && addr_lo[0])
            || (size == SZ_W && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the bridge: store byte mask and data replication, load lane
// select with sign/zero extension.
module lsu_align
    import dram_lsu_bridge_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] spo_i,
    output logic [3:0]  be_o,
    output logic [31:0] wrep_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = spo_i[{off_i, 3'b000} +: 8];
    assign half_lane = off_i[1] ? spo_i[31:16] : spo_i[15:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be_o    = 4'b0000;
        wrep_o  = 32'h0;
        rdata_o = 32'h0;
        unique case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wrep_o  = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
            end
            SZ_H: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wrep_o  = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wrep_o  = wdata_i;
                rdata_o = spo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dram_lsu_bridge.sv
// MEM-stage load/store front-end for the simulation data RAM, with optional
// wait states between acceptance and the single-cycle RAM access.
module dram_lsu_bridge
    import dram_lsu_bridge_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 20,
    parameter logic [31:0] BASE_ADDR   = 32'h1c00_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_BITS-1:0] dram_a,
    output logic [3:0]           dram_we,
    output logic [31:0]          dram_d,
    input  logic [31:0]          dram_spo
);

    localparam int unsigned OFF_W = ADDR_BITS + 2;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    size_e              size_q, size_d;
    logic               uns_q, uns_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        acc_off;
    logic               acc_err;
    logic [3:0]         be_mask;
    logic [31:0]        ld_data;

    // Addresses below BASE_ADDR wrap to huge offsets and so fail the window test too.
    assign acc_off = req_addr - BASE_ADDR;
    assign acc_err = bad_shape(req_size, req_addr[1:0]) || ((acc_off >> OFF_W) != 32'd0);

    lsu_align u_align (
        .size_i     (size_q),
        .off_i      (off_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .spo_i      (dram_spo),
        .be_o       (be_mask),
        .wrep_o     (dram_d),
        .rdata_o    (ld_data)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dram_a     = off_q[OFF_W-1:2];
    // Gated by rst directly so a store caught in ACCESS during reset never lands.
    assign dram_we    = (state_q == ST_ACCESS && we_q && !rst) ? be_mask : 4'b0000;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    off_d   = acc_off[OFF_W-1:0];
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = acc_err;
                    if (acc_err) begin
                        state_d = ST_RESP;
                    end else if (WAIT_CYCLES != 0) begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ACCESS: begin
                rdata_d = we_q ? 32'h0 : ld_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            off_q   <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_lsu_bridge.sv
// Randomized self-checking bench: two bridges (0 and 3 wait states) each backed
// by a byte-enable RAM, compared against a byte-array reference model.
module tb_dram_lsu_bridge;

    localparam int          AB    = 10;
    localparam logic [31:0] BASE  = 32'h1c00_0000;
    localparam int          WIN   = 4 * (1 << AB);
    localparam int          WORDS = 1 << AB;

    logic          clk;
    logic          rst;
    logic          ram_init;
    logic          req_valid    [2];
    logic          req_ready    [2];
    logic          req_we       [2];
    logic [1:0]    req_size     [2];
    logic          req_unsigned [2];
    logic [31:0]   req_addr     [2];
    logic [31:0]   req_wdata    [2];
    logic          resp_valid   [2];
    logic          resp_ready   [2];
    logic [31:0]   resp_rdata   [2];
    logic          resp_err     [2];
    logic [AB-1:0] dram_a       [2];
    logic [3:0]    dram_we      [2];
    logic [31:0]   dram_d       [2];
    logic [31:0]   dram_spo     [2];

    logic [31:0]   ram   [2][WORDS];
    logic [7:0]    ref_b [2][WIN];

    int            acc_cnt [2];
    logic [3:0]    last_we [2];
    logic [AB-1:0] last_a  [2];
    logic [31:0]   last_d  [2];

    int errors = 0;
    int checks = 0;

    dram_lsu_bridge #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .dram_a(dram_a[0]),
        .dram_we(dram_we[0]), .dram_d(dram_d[0]), .dram_spo(dram_spo[0])
    );

    dram_lsu_bridge #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .dram_a(dram_a[1]),
        .dram_we(dram_we[1]), .dram_d(dram_d[1]), .dram_spo(dram_spo[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int u, input int i);
        return (i * 32'h9e37_79b1) ^ ((u != 0) ? 32'h5a5a_0f0f : 32'h1234_5678);
    endfunction

    // RAM: async read, byte-enable write on posedge.
    assign dram_spo[0] = ram[0][dram_a[0]];
    assign dram_spo[1] = ram[1][dram_a[1]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int u = 0; u < 2; u++)
                for (int i = 0; i < WORDS; i++)
                    ram[u][i] <= init_word(u, i);
        end else begin
            for (int u = 0; u < 2; u++)
                for (int k = 0; k < 4; k++)
                    if (dram_we[u][k]) ram[u][dram_a[u]][8*k +: 8] <= dram_d[u][8*k +: 8];
        end
    end

    // Records every cycle with a nonzero write enable.
    initial begin
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
    end
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (dram_we[u] != 4'b0000) begin
                acc_cnt[u] <= acc_cnt[u] + 1;
                last_we[u] <= dram_we[u];
                last_a[u]  <= dram_a[u];
                last_d[u]  <= dram_d[u];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete transaction on unit u, with the response held off for 'hold' cycles.
    task automatic txn(input int u, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] off, exp_rd, exp_d, ext_mask;
        logic [3:0]  exp_mask;
        bit          exp_e;
        int          n, lat, exp_lat, acc0;

        off    = addr - BASE;
        exp_e  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)
              || (off >= WIN);
        n        = 1 << sz;
        exp_rd   = 32'h0;
        exp_d    = 32'h0;
        exp_mask = 4'b0000;
        if (!exp_e) begin
            if (we) begin
                for (int i = 0; i < 4; i++) exp_d[8*i +: 8] = wd[8*(i % n) +: 8];
                exp_mask = 4'((1 << n) - 1) << off[1:0];
            end else begin
                for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_b[u][int'(off) + i];
                ext_mask = (n == 4) ? 32'hffff_ffff : ((32'd1 << (8 * n)) - 32'd1);
                if (!uns && exp_rd[8*n - 1]) exp_rd = exp_rd | ~ext_mask;
            end
        end
        exp_lat = exp_e ? 1 : 2 + ((u == 0) ? 0 : 3);

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[u]), 32'd1);
        acc0            = acc_cnt[u];
        req_we[u]       = we;
        req_size[u]     = sz;
        req_unsigned[u] = uns;
        req_addr[u]     = addr;
        req_wdata[u]    = wd;
        req_valid[u]    = 1'b1;
        @(posedge clk);
        #1 req_valid[u] = 1'b0;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!resp_valid[u] && lat < exp_lat) check("busy_ready", 32'(req_ready[u]), 32'd0);
        end while (!resp_valid[u] && lat < 40);
        check("latency", lat, exp_lat);
        check("resp_err", 32'(resp_err[u]), 32'(exp_e));
        check("resp_rdata", resp_rdata[u], exp_rd);

        req_we[u]   = 1'b0;
        req_size[u] = 2'd2;
        req_addr[u] = BASE;
        for (int h = 0; h < hold; h++) begin
            req_valid[u] = 1'b1;
            @(negedge clk);
            check("stall_valid", 32'(resp_valid[u]), 32'd1);
            check("stall_rdata", resp_rdata[u], exp_rd);
            check("stall_err", 32'(resp_err[u]), 32'(exp_e));
            check("stall_ready", 32'(req_ready[u]), 32'd0);
        end
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[u] = 1'b0;
        req_valid[u]  = 1'b0;

        check("access_cnt", acc_cnt[u] - acc0, (we && !exp_e) ? 1 : 0);
        if (we && !exp_e) begin
            check("dram_we", 32'(last_we[u]), 32'(exp_mask));
            check("dram_d", last_d[u], exp_d);
            check("dram_a", 32'(last_a[u]), off >> 2);
            for (int i = 0; i < n; i++) ref_b[u][int'(off) + i] = wd[8*i +: 8];
        end
    endtask

    // Reset asserted during the ACCESS cycle of a word store on unit 0.
    task automatic reset_in_access(input logic [31:0] addr, input logic [31:0] wd);
        bit found;
        logic [31:0] off, w;
        off = addr - BASE;
        @(negedge clk);
        req_we[0]       = 1'b1;
        req_size[0]     = 2'd2;
        req_unsigned[0] = 1'b0;
        req_addr[0]     = addr;
        req_wdata[0]    = wd;
        req_valid[0]    = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (dram_we[0] != 4'b0000) found = 1'b1;
        end
        check("rst_found_access", 32'(found), 32'd1);
        rst = 1'b1;
        #1 check("rst_we_gated", 32'(dram_we[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst_no_resp", 32'(resp_valid[0]), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_b[0][int'(off) + k];
        check("rst_ram_word", ram[0][off[AB+1:2]], w);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w, off, addr;
        logic [1:0]  sz;
        int          mism, u;

        for (int uu = 0; uu < 2; uu++) begin
            req_valid[uu] = 1'b0; req_we[uu] = 1'b0; req_size[uu] = 2'd0;
            req_unsigned[uu] = 1'b0; req_addr[uu] = 32'h0; req_wdata[uu] = 32'h0;
            resp_ready[uu] = 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                w = init_word(uu, i);
                for (int k = 0; k < 4; k++) ref_b[uu][4*i + k] = w[8*k +: 8];
            end
        end
        ram_init = 1'b1;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp_err", 32'(resp_err[0]), 32'd0);
        check("rst_resp_rdata", resp_rdata[0], 32'h0);
        check("rst_dram_we", 32'(dram_we[0]), 32'd0);
        check("rst_dram_a", 32'(dram_a[0]), 32'd0);

        txn(0, 1, 2'd2, 0, 32'h1c00_0008, 32'hdead_beef, 0);
        txn(0, 0, 2'd2, 0, 32'h1c00_0008, 32'h0, 0);
        txn(0, 1, 2'd0, 0, 32'h1c00_0011, 32'h0000_0080, 0);
        txn(0, 0, 2'd0, 0, 32'h1c00_0011, 32'h0, 0);
        txn(0, 0, 2'd0, 1, 32'h1c00_0011, 32'h0, 0);
        txn(0, 0, 2'd1, 0, 32'h1c00_0003, 32'h0, 0);
        txn(0, 1, 2'd2, 0, 32'h1bff_fffc, 32'h1111_2222, 0);
        txn(0, 0, 2'd2, 0, BASE + WIN, 32'h0, 0);
        txn(0, 0, 2'd3, 0, 32'h1c00_0008, 32'h0, 0);
        txn(0, 0, 2'd2, 0, 32'h1c00_0008, 32'h0, 4);
        txn(1, 0, 2'd2, 0, 32'h1c00_0040, 32'h0, 0);
        txn(1, 0, 2'd1, 0, 32'h1c00_0041, 32'h0, 2);
        txn(1, 1, 2'd1, 0, 32'h1c00_0042, 32'h0000_8001, 0);
        txn(1, 0, 2'd1, 0, 32'h1c00_0042, 32'h0, 0);
        reset_in_access(32'h1c00_0020, 32'hcafe_f00d);
        txn(0, 0, 2'd2, 0, 32'h1c00_0020, 32'h0, 0);

        for (int t = 0; t < 240; t++) begin
            u  = int'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            off = 32'($urandom_range(0, WIN - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) off = off & ~((32'd1 << sz) - 32'd1);
            addr = BASE + off;
            case ($urandom_range(0, 11))
                0: addr = BASE + WIN + 32'($urandom_range(0, 255)) * 4;
                1: addr = BASE - 32'($urandom_range(1, 64)) * 4;
                default: ;
            endcase
            txn(u, $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, addr, $urandom,
                int'($urandom_range(0, 3)));
        end

        mism = 0;
        for (int uu = 0; uu < 2; uu++)
            for (int i = 0; i < WORDS; i++) begin
                for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_b[uu][4*i + k];
                if (ram[uu][i] !== w) mism++;
            end
        check("ram_image", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_lsu_bridge.md
Name: dram_lsu_bridge

Overview:
- Load/store front-end directly upstream of the simulation data RAM (word-addressed, async read, byte-enable write on posedge).
- Accepts one byte/half/word request at a time from the MEM stage over a valid/ready handshake and drives the RAM's address, byte-enable and write-data ports.
- Returns sign/zero-extended load data or a store acknowledge over a valid/ready response channel.
- Models a configurable number of wait states so pipeline stall logic can be exercised.

Parameters:
- ADDR_BITS, 20, RAM word-address width; window size is 4*2^ADDR_BITS bytes.
- BASE_ADDR, 32'h1c00_0000, byte address mapped to RAM word 0.
- WAIT_CYCLES, 0, extra idle cycles between acceptance and the RAM access (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend the load when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-window or reserved size
- dram_a  out  ADDR_BITS  RAM word address
- dram_we  out  4  RAM byte write enables
- dram_d  out  32  RAM write data
- dram_spo  in  32  RAM async read data; byte lane k = bits [8k+7:8k]

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP. Reset → IDLE; resp_valid=0, resp_err=0, resp_rdata=0, latched request = 0.
- IDLE: req_ready=1. On req_valid && req_ready, latch all req_* fields and compute off = req_addr - BASE_ADDR (32-bit).
- Error check at acceptance: err if size==11, half with addr[0]=1, word with addr[1:0]!=0, or off >= 4*2^ADDR_BITS (unsigned; wrap below BASE counts as out of window).
  - Err → RESP directly, resp_err=1, resp_rdata=0. No ACCESS state and no RAM write.
- No error, WAIT_CYCLES>0 → WAIT with counter = WAIT_CYCLES-1. WAIT decrements the counter and moves to ACCESS after the cycle in which it is 0.
- No error, WAIT_CYCLES=0 → ACCESS.
- ACCESS lasts exactly one cycle.
  - dram_we = byte mask: byte 1<<off[1:0], half 0011 or 1100 by off[1], word 1111. Loads use 0000.
  - The store commits at the clock edge ending ACCESS.
  - Loads capture dram_spo at that same edge: select lane(s) by off[1:0], then sign- or zero-extend to 32 bits.
  - Next state is RESP.
- Latency: request accepted at edge N; resp_valid is high from cycle N+1+WAIT_CYCLES (+1 for non-error requests). Err responses appear at N+1 regardless of WAIT_CYCLES.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready. On resp_valid && resp_ready → IDLE. req_ready=0 in WAIT/ACCESS/RESP; the next request can be accepted at the earliest the cycle after the handshake.
- dram_a = off[ADDR_BITS+1:2] of the latched request in all states.
- dram_d: byte replicated x4, half replicated x2, word as-is.
- dram_we = 0 in all states other than ACCESS, and forced 0 whenever rst=1.
- Reset mid-operation: any state → IDLE at the edge; the pending request is dropped with no response. A store in ACCESS with rst high does not write.

Decomposition:
- common.vh: size encodings (SZ_B/SZ_H/SZ_W) and state encodings.
- Sub-module lsu_align (combinational) for byte-mask and store-data replication generation plus load lane select/extension; the FSM lives in dram_lsu_bridge.

Test Plan:
- st.w 0x1c000008 data 0xdeadbeef, WAIT_CYCLES=0 → one ACCESS cycle with dram_a=2, dram_we=1111; resp_valid 2 cycles after accept with err=0; a following ld.w returns 0xdeadbeef.
- st.b 0x1c000011 data 0x80, then ld.b and ld.bu same addr → dram_we=0010, dram_d=0x80808080; rdata 0xffffff80 and 0x00000080.
- ld.h 0x1c000003 → resp_err=1, rdata=0, no ACCESS cycle, dram_we never nonzero; address 0x1bfffffc → also err.
- WAIT_CYCLES=3, ld.w → resp_valid exactly 5 cycles after accept; req_ready=0 throughout.
- resp_ready held low for 4 cycles → resp_valid/rdata stable, req_ready=0, a new req_valid is not accepted until the cycle after the handshake.
- rst pulsed during the ACCESS cycle of st.w → RAM word unchanged, no response, req_ready=1 the cycle after reset.
